// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared sizing constants and types for the data memory behind the L1 D-cache.
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  byte-address width
//   DEPTH_LOG2  log2 of the word count
//   WORD_BYTES  bytes per word (addr[1:0] selects a byte and is ignored)
//   DEPTH       number of words
// Types: word_t (one data word), widx_t (word index into the array).
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH_LOG2 = 12;
  localparam int WORD_BYTES = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // Index of the lowest address bit that selects a word.
  localparam int IDX_LSB = $clog2(WORD_BYTES);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [DEPTH_LOG2-1:0] widx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Word index from a byte address. Upper bits drop out, so addresses alias
  // modulo DEPTH words.
  function automatic widx_t word_index(input addr_t a);
    return a[IDX_LSB +: DEPTH_LOG2];
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Bus between the L1 data cache (master) and the data memory (slave).
//   addr        byte address from the cache
//   write_data  store data
//   memwrite    1 = write the addressed word on the next rising clk edge
//   read_data   combinational contents of the addressed word
// -----------------------------------------------------------------------------
interface data_mem_if;
  import data_mem_pkg::*;

  addr_t addr;
  word_t write_data;
  logic  memwrite;
  word_t read_data;

  modport master (
    output addr,
    output write_data,
    output memwrite,
    input  read_data
  );

  modport slave (
    input  addr,
    input  write_data,
    input  memwrite,
    output read_data
  );

endinterface

// File: rtl/data_mem_valid.sv
// -----------------------------------------------------------------------------
// data_mem_valid
// One valid bit per memory word. All bits clear asynchronously on reset; a bit
// is set when its word is written. Lookup is combinational.
//   clk           clock
//   rst_n         asynchronous active-low clear of every valid bit
//   i_set_en      set the bit at i_set_idx on the rising edge
//   i_set_idx     word index to mark valid
//   i_lookup_idx  word index to query
//   o_valid       valid bit of i_lookup_idx
// -----------------------------------------------------------------------------
module data_mem_valid
  import data_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_set_en,
  input  widx_t i_set_idx,
  input  widx_t i_lookup_idx,
  output logic  o_valid
);

  logic [DEPTH-1:0] r_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_set_en) begin
      r_valid[i_set_idx] <= 1'b1;
    end
  end

  assign o_valid = r_valid[i_lookup_idx];

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-organised data memory behind the L1 data cache. Combinational read,
// synchronous write. Words never written since reset read as zero.
//   clk    clock; writes happen on the rising edge
//   rst_n  asynchronous active-low reset (clears valid bits only)
//   bus    data_mem_if.slave: addr, write_data, memwrite in; read_data out
// Optional build macro:
//   DATA_MEM_FWD_EN  write-first: while memwrite=1, read_data shows
//                    write_data before the edge. Undefined: read-before-write.
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);

  widx_t w_idx;
  logic  w_wr_en;
  logic  w_valid;
  logic  w_addr_unused;
  word_t r_mem [DEPTH];

  assign w_idx   = word_index(bus.addr);
  // Gating with rst_n makes reset win when it is held across a write edge.
  assign w_wr_en = bus.memwrite & rst_n;

  // Byte-select bits and bits above the index do not take part in the access.
  assign w_addr_unused = ^{bus.addr[ADDR_WIDTH-1:IDX_LSB+DEPTH_LOG2],
                           bus.addr[IDX_LSB-1:0]};

  data_mem_valid u_valid (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (w_wr_en),
    .i_set_idx    (w_idx),
    .i_lookup_idx (w_idx),
    .o_valid      (w_valid)
  );

  // NOTE: the storage array has no reset; the valid bits give the defined
  // post-reset image, which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= bus.write_data;
    end
  end

  // NOTE: read_data gets a default first so no path through the block leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    bus.read_data = '0;
    if (w_valid) begin
      bus.read_data = r_mem[w_idx];
    end
`ifdef DATA_MEM_FWD_EN
    if (w_wr_en) begin
      bus.read_data = bus.write_data;
    end
`endif
  end

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Directed bench for data_mem: reset image, write/read, byte-offset and alias
// addressing, read-during-write, asynchronous reset clearing, reset over a
// write edge and a write right after reset release.
// -----------------------------------------------------------------------------
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  data_mem_if bus ();

  data_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t observed, input word_t expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present an address away from clock edges and compare the read.
  task automatic rd_check(input string tag, input addr_t a, input word_t expected);
    bus.addr = a;
    #1;
    check(tag, bus.read_data, expected);
  endtask

  // One write edge; returns 1 time unit after the edge with memwrite low.
  task automatic do_write(input addr_t a, input word_t d);
    bus.addr       = a;
    bus.write_data = d;
    bus.memwrite   = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;
    bus.memwrite   = 1'b0;

    rd_check("reset_active_0x0", 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up image reads as zero.
    rd_check("reset_0x0",    32'h0000_0000, 32'h0);
    rd_check("reset_0x40",   32'h0000_0040, 32'h0);
    rd_check("reset_0xFFFC", 32'h0000_FFFC, 32'h0);

    // Basic write; byte offset ignored; neighbour untouched.
    do_write(32'h10, 32'hDEAD_BEEF);
    rd_check("wr_0x10", 32'h10, 32'hDEAD_BEEF);
    rd_check("wr_0x11", 32'h11, 32'hDEAD_BEEF);
    rd_check("wr_0x13", 32'h13, 32'hDEAD_BEEF);
    rd_check("nbr_0x14", 32'h14, 32'h0);
    rd_check("nbr_0x0C", 32'h0C, 32'h0);

    // Alias wrap-around modulo 4096 words.
    do_write(32'h4, 32'hCAFE_F00D);
    rd_check("alias_0x4004", 32'h4004, 32'hCAFE_F00D);
    rd_check("alias_hi",     32'hFFFF_0004, 32'hCAFE_F00D);
    do_write(32'h3FFC, 32'h0BAD_F00D);
    rd_check("last_word",    32'h3FFC, 32'h0BAD_F00D);
    rd_check("last_alias",   32'h7FFC, 32'h0BAD_F00D);
    rd_check("first_intact", 32'h0000, 32'h0);

    // Read during write to the same word.
    do_write(32'h20, 32'h1111_1111);
    bus.addr       = 32'h20;
    bus.write_data = 32'h2222_2222;
    bus.memwrite   = 1'b1;
    #1;
`ifdef DATA_MEM_FWD_EN
    check("rdw_before_edge", bus.read_data, 32'h2222_2222);
`else
    check("rdw_before_edge", bus.read_data, 32'h1111_1111);
`endif
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    check("rdw_after_edge", bus.read_data, 32'h2222_2222);

    // Asynchronous reset pulse between edges clears everything.
    do_write(32'h8, 32'h1234_5678);
    rd_check("pre_pulse_0x8", 32'h8, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    check("pulse_0x8_async", bus.read_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("pulse_0x8_released", bus.read_data, 32'h0);
    @(posedge clk);
    #1;
    check("pulse_0x8_next_edge", bus.read_data, 32'h0);
    rd_check("pulse_0x10_cleared", 32'h10, 32'h0);
    rd_check("pulse_alias_cleared", 32'h4004, 32'h0);

    // Reset held across a write edge drops the write.
    @(negedge clk);
    rst_n          = 1'b0;
    bus.addr       = 32'hC;
    bus.write_data = 32'hA5A5_A5A5;
    bus.memwrite   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_over_write_during", bus.read_data, 32'h0);
    @(negedge clk);
    bus.memwrite = 1'b0;
    rst_n        = 1'b1;
    rd_check("rst_over_write_after", 32'hC, 32'h0);

    // Reset released mid-cycle: next edge writes normally.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    do_write(32'hC, 32'h5A5A_5A5A);
    rd_check("write_after_release", 32'hC, 32'h5A5A_5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
